down_timer: RTL and testbench
=============================

# down_timer

Countdown timer for the clock design: four BCD digits in MM:SS form (00:00 to 99:59) that count down on each one-cycle `tick` enable. It runs from a preset value to 00:00, then raises a one-cycle `done` pulse and holds `alarm`. It takes the same 1 Hz enable that the up-counting time chain uses and drives the same digit display path.

## Interface
Parameters: none; digit widths fixed at 4 bits BCD.

Ports:
- in_clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- tick  input  1  one-cycle count enable (1 Hz strobe), synchronous to in_clk
- load  input  1  load preset digits, one-cycle pulse
- clear  input  1  force count to 00:00 and state to IDLE
- start  input  1  begin/resume counting
- stop  input  1  pause counting
- pre_mt, pre_mu, pre_st, pre_su  input  4 each  preset digits: minute tens, minute units, second tens, second units
- min_t, min_u, sec_t, sec_u  output  4 each  current count digits, registered
- running  output  1  high while in RUN
- done  output  1  one-cycle pulse on reaching 00:00 from RUN
- alarm  output  1  level, high while in DONE

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset (rst low, async):
  - all digits 0, state IDLE.
  - running, done and alarm all 0.
- Priority, highest first: clear, load, stop, start, tick.
- clear (any state): digits ← 0, state ← IDLE, alarm ← 0.
- load (any state):
  - digits ← presets, state ← IDLE.
  - Clamping: any digit >9 loads 9; pre_st >5 loads 5.
- start:
  - From IDLE or PAUSE with count ≠ 00:00: go to RUN.
  - Count = 00:00: start is ignored.
  - In RUN or DONE: start is ignored.
- stop:
  - RUN → PAUSE.
  - In any other state: ignored.
  - stop and start asserted together: stop wins.
- tick in RUN: decrement MM:SS by one second.
  - sec_u: 0 wraps to 9 with borrow, else decrements.
  - sec_t: on borrow, 0 wraps to 5 with borrow, else decrements.
  - min_u: on borrow, 0 wraps to 9 with borrow, else decrements.
  - min_t: on borrow, decrements. Never underflows, because RUN is left at 00:00.
- Reaching 00:00:
  - The decrement that produces 00:00 also moves the state to DONE in the same edge.
  - done pulses for the following cycle only.
  - alarm holds until clear or load.
- tick outside RUN: ignored. Digits hold in IDLE, PAUSE and DONE.
- tick coincident with stop/load/clear: the higher-priority event wins and no decrement occurs.

## Timing
- All outputs are registered; no combinational path from input to output.
- tick sampled at edge N: new digits are visible after edge N; done/alarm are high after the same edge N when the count reaches 00:00.
- done is high for exactly 1 in_clk cycle per expiry.
- running = (state == RUN), registered alongside state.
- load/clear take effect at the next edge. Digits are valid the cycle after.
- start takes effect at the next edge. A tick in that same cycle is not counted; the first decrement needs a later tick.
- Reset mid-RUN: outputs go to reset values immediately (async) and stay there until rst deasserts. No done pulse.

## Test plan
- Reset then load 01:00, start, 1 tick:
  - Expected count 00:59 (min_u=0, sec_t=5, sec_u=9).
  - done = 0, running = 1.
- Load 00:02, start, 2 ticks:
  - Count 00:01, then 00:00.
  - done high exactly 1 cycle; alarm=1, running=0.
  - A further tick leaves the count at 00:00.
- Load 10:00, start, 1 tick:
  - Count 09:59, showing the full borrow chain across all digits.
- Load 05:30, start, tick, then stop and tick asserted in the same cycle:
  - Count 05:29, state PAUSE.
  - Count holds 05:29 through 3 more ticks.
  - start then resumes, and the next tick gives 05:28.
- Load with presets mt=12, mu=15, st=7, su=10:
  - Count clamps to 99:59.
  - start with 00:00 loaded: running stays 0.
- While RUN at 00:40:
  - Assert clear and tick together → 00:00, IDLE, done=0, alarm=0.
  - Drop rst mid-RUN: all outputs go to 0 without waiting for an in_clk edge.

Source files
------------

// File: rtl/down_timer.sv
// MM:SS BCD countdown timer driven by a one-cycle tick enable.
// Counts from a loaded preset down to 00:00, then pulses done and holds alarm.
module down_timer (
    input  logic       in_clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] pre_mt,
    input  logic [3:0] pre_mu,
    input  logic [3:0] pre_st,
    input  logic [3:0] pre_su,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    logic [DW-1:0] dec_mt, dec_mu, dec_st, dec_su;
    logic          cnt_zero;
    logic          cnt_one;

    function automatic logic [DW-1:0] clamp(input logic [DW-1:0] d, input logic [DW-1:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    assign cnt_zero = (min_t == '0) && (min_u == '0) && (sec_t == '0) && (sec_u == '0);
    assign cnt_one  = (min_t == '0) && (min_u == '0) && (sec_t == '0) && (sec_u == DW'(1));

    // One-second decrement with BCD borrow chain (seconds tens wrap at 5).
    always_comb begin
        dec_mt = min_t;
        dec_mu = min_u;
        dec_st = sec_t;
        dec_su = DW'(sec_u - DW'(1));
        if (sec_u == '0) begin
            dec_su = DW'(9);
            if (sec_t == '0) begin
                dec_st = DW'(5);
                if (min_u == '0) begin
                    dec_mu = DW'(9);
                    dec_mt = DW'(min_t - DW'(1));
                end else begin
                    dec_mu = DW'(min_u - DW'(1));
                end
            end else begin
                dec_st = DW'(sec_t - DW'(1));
            end
        end
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            min_t   <= '0;
            min_u   <= '0;
            sec_t   <= '0;
            sec_u   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state   <= IDLE;
                min_t   <= '0;
                min_u   <= '0;
                sec_t   <= '0;
                sec_u   <= '0;
                running <= 1'b0;
                alarm   <= 1'b0;
            end else if (load) begin
                state   <= IDLE;
                min_t   <= clamp(pre_mt, DW'(9));
                min_u   <= clamp(pre_mu, DW'(9));
                sec_t   <= clamp(pre_st, DW'(5));
                sec_u   <= clamp(pre_su, DW'(9));
                running <= 1'b0;
                alarm   <= 1'b0;
            end else if (stop) begin
                if (state == RUN) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end
            end else if (state == RUN) begin
                // start is meaningless while running, so a tick still counts here
                if (tick) begin
                    min_t <= dec_mt;
                    min_u <= dec_mu;
                    sec_t <= dec_st;
                    sec_u <= dec_su;
                    if (cnt_one) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                        alarm   <= 1'b1;
                    end
                end
            end else if (start) begin
                if ((state == IDLE || state == PAUSE) && !cnt_zero) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Directed-vector bench for down_timer with hand-computed expected counts.
module tb_down_timer;

    logic       in_clk;
    logic       rst;
    logic       tick, load, clear, start, stop;
    logic [3:0] pre_mt, pre_mu, pre_st, pre_su;
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       running, done, alarm;

    int n_checks;
    int n_fail;

    down_timer dut (
        .in_clk  (in_clk),
        .rst     (rst),
        .tick    (tick),
        .load    (load),
        .clear   (clear),
        .start   (start),
        .stop    (stop),
        .pre_mt  (pre_mt),
        .pre_mu  (pre_mu),
        .pre_st  (pre_st),
        .pre_su  (pre_su),
        .min_t   (min_t),
        .min_u   (min_u),
        .sec_t   (sec_t),
        .sec_u   (sec_u),
        .running (running),
        .done    (done),
        .alarm   (alarm)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cnt();
        return {min_t, min_u, sec_t, sec_u};
    endfunction

    function automatic logic [2:0] flags();
        return {running, done, alarm};
    endfunction

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] mt, input logic [3:0] mu,
                           input logic [3:0] st, input logic [3:0] su);
        pre_mt = mt; pre_mu = mu; pre_st = st; pre_su = su;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        tick = 0; load = 0; clear = 0; start = 0; stop = 0;
        pre_mt = 0; pre_mu = 0; pre_st = 0; pre_su = 0;

        #12;
        check("reset_cnt", 32'(cnt()), 32'h0000);
        check("reset_flags", 32'(flags()), 32'b000);
        @(negedge in_clk);
        rst = 1'b1;
        step();

        // 01:00 -> 00:59
        do_load(4'd0, 4'd1, 4'd0, 4'd0);
        check("load_0100", 32'(cnt()), 32'h0100);
        check("load_0100_flags", 32'(flags()), 32'b000);
        do_start();
        check("start_running", 32'(running), 32'd1);
        do_tick();
        check("tick_0059", 32'(cnt()), 32'h0059);
        check("tick_0059_flags", 32'(flags()), 32'b100);

        // 00:02 expiry
        do_load(4'd0, 4'd0, 4'd0, 4'd2);
        check("reload_idle", 32'(flags()), 32'b000);
        do_start();
        do_tick();
        check("exp_0001", 32'(cnt()), 32'h0001);
        check("exp_0001_flags", 32'(flags()), 32'b100);
        do_tick();
        check("exp_0000", 32'(cnt()), 32'h0000);
        check("exp_done_flags", 32'(flags()), 32'b011);
        step();
        check("exp_done_pulse_end", 32'(flags()), 32'b001);
        do_tick();
        check("exp_hold_cnt", 32'(cnt()), 32'h0000);
        check("exp_hold_flags", 32'(flags()), 32'b001);
        do_start();
        check("start_in_done", 32'(flags()), 32'b001);

        // Full borrow chain 10:00 -> 09:59; load clears alarm
        do_load(4'd1, 4'd0, 4'd0, 4'd0);
        check("load_clears_alarm", 32'(flags()), 32'b000);
        do_start();
        do_tick();
        check("borrow_0959", 32'(cnt()), 32'h0959);

        // Pause / resume at 05:30
        do_load(4'd0, 4'd5, 4'd3, 4'd0);
        do_start();
        do_tick();
        check("pause_0529", 32'(cnt()), 32'h0529);
        stop = 1'b1; tick = 1'b1;
        step();
        stop = 1'b0; tick = 1'b0;
        check("stop_tick_cnt", 32'(cnt()), 32'h0529);
        check("stop_tick_flags", 32'(flags()), 32'b000);
        for (int i = 0; i < 3; i++) do_tick();
        check("pause_hold", 32'(cnt()), 32'h0529);
        do_start();
        check("resume_running", 32'(running), 32'd1);
        check("resume_cnt", 32'(cnt()), 32'h0529);
        do_tick();
        check("resume_0528", 32'(cnt()), 32'h0528);

        // Clamping and start at zero
        do_load(4'd12, 4'd15, 4'd7, 4'd10);
        check("clamp_9959", 32'(cnt()), 32'h9959);
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        do_start();
        check("start_zero", 32'(flags()), 32'b000);

        // start+tick same cycle does not decrement; then clear+tick at 00:40
        do_load(4'd0, 4'd0, 4'd4, 4'd1);
        start = 1'b1; tick = 1'b1;
        step();
        start = 1'b0; tick = 1'b0;
        check("start_tick_cnt", 32'(cnt()), 32'h0041);
        check("start_tick_run", 32'(running), 32'd1);
        do_tick();
        check("run_0040", 32'(cnt()), 32'h0040);
        clear = 1'b1; tick = 1'b1;
        step();
        clear = 1'b0; tick = 1'b0;
        check("clear_cnt", 32'(cnt()), 32'h0000);
        check("clear_flags", 32'(flags()), 32'b000);
        do_tick();
        check("clear_idle_hold", 32'(cnt()), 32'h0000);

        // Async reset mid-RUN
        do_load(4'd0, 4'd0, 4'd4, 4'd0);
        do_start();
        do_tick();
        check("pre_rst_0039", 32'(cnt()), 32'h0039);
        #2 rst = 1'b0;
        #1;
        check("async_rst_cnt", 32'(cnt()), 32'h0000);
        check("async_rst_flags", 32'(flags()), 32'b000);
        tick = 1'b1;
        step();
        step();
        tick = 1'b0;
        check("rst_held_cnt", 32'(cnt()), 32'h0000);
        check("rst_held_flags", 32'(flags()), 32'b000);
        rst = 1'b1;
        do_tick();
        check("post_rst_idle", 32'(cnt()), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
